// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: default bit timing,
// transmit state encoding and frame geometry.
package uart_tx_buffered_pkg;

  // 80 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 694;

  // 8N1 frame: one start bit, eight data bits, one stop bit
  localparam int FRAME_DATA_BITS = 8;
  localparam int FRAME_BITS      = FRAME_DATA_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous write FIFO for the UART transmitter. Flags and level are
// registered; a push into a full FIFO is accepted only when a pop happens in
// the same cycle, otherwise it is dropped and flagged one cycle later.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leave the level unchanged
  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (do_pop && !do_push) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  // Byte storage carries no reset; pointers decide what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, registered flags and the dropped-write pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level    <= level_nxt;
      full     <= (level_nxt == LVL_W'(DEPTH));
      empty    <= (level_nxt == '0);
      overflow <= push && !do_push;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small write FIFO. Queued bytes are sent
// LSB first and back-to-back: the stop bit of one frame is followed directly
// by the start bit of the next whenever the FIFO holds data at that edge.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_Write,
  input  logic [7:0]                    i_Data,
  output logic                          o_TX,
  output logic                          o_Busy,
  output logic                          o_Done,
  output logic                          o_Full,
  output logic                          o_Empty,
  output logic                          o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Level
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]        BIT_LAST = 3'(FRAME_DATA_BITS - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       head;
  logic             bit_end;
  logic             pop;

  assign bit_end = (baud_cnt == CNT_LAST);

  // A byte leaves the FIFO when idle, or at the very end of a stop bit so the
  // next start bit follows with no gap. The empty flag is registered, so a
  // write landing on that same edge is picked up one cycle later from IDLE.
  assign pop = !o_Empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  uart_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_Clock),
    .rst_n    (i_Reset_n),
    .push     (i_Write),
    .pop      (pop),
    .wr_data  (i_Data),
    .rd_data  (head),
    .full     (o_Full),
    .empty    (o_Empty),
    .level    (o_Level),
    .overflow (o_Overflow)
  );

  // Shift register: loaded on pop, advanced at the end of every data bit
  always_ff @(posedge i_Clock) begin
    if (pop) begin
      shift <= head;
    end else if ((state == ST_DATA) && bit_end) begin
      shift <= shift >> 1;
    end
  end

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      o_TX     <= 1'b1;
      o_Busy   <= 1'b0;
      o_Done   <= 1'b0;
    end else begin
      // Done is raised one edge early so it covers the last stop-bit cycle
      o_Done <= (state == ST_STOP) && (baud_cnt == CNT_PRE);
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          o_TX     <= 1'b1;
          if (pop) begin
            o_TX   <= 1'b0;
            o_Busy <= 1'b1;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            o_TX     <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              o_TX    <= 1'b1;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_TX    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              o_TX  <= 1'b0;
              state <= ST_START;
            end else begin
              o_Busy <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 694 clocks per bit, FIFO depth 4.
// A line monitor decodes o_TX at mid-bit and queues each decoded byte with
// the edge count at which its start bit began.
module tb_uart_tx_buffered;

  localparam int CLKS  = 694;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CLKS;
  localparam int HALF  = CLKS / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       done;
  logic       full;
  logic       empty;
  logic       ovf;
  logic [2:0] level;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] q_byte [$];
  int         q_start[$];
  logic       q_ok   [$];

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CLKS),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_Write    (wr),
    .i_Data     (data),
    .o_TX       (tx),
    .o_Busy     (busy),
    .o_Done     (done),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Overflow (ovf),
    .o_Level    (level)
  );

  // Edge counter: value seen #1 after an edge equals the number of edges so far
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Line monitor, aborted by reset
  initial begin
    int         mcnt;
    int         mstart;
    bit         mon;
    logic       mstart_ok;
    logic [7:0] msh;
    mon = 1'b0;
    mcnt = 0;
    mstart = 0;
    mstart_ok = 1'b0;
    msh = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon = 1'b0;
      end else if (!mon) begin
        if (tx === 1'b0) begin
          mon = 1'b1;
          mcnt = 0;
          mstart = cyc;
        end
      end else begin
        mcnt++;
        if (mcnt == HALF) begin
          mstart_ok = (tx === 1'b0);
        end else if ((mcnt > HALF) && (((mcnt - HALF) % CLKS) == 0)) begin
          if (((mcnt - HALF) / CLKS) <= 8) begin
            msh = {tx, msh[7:1]};
          end else begin
            q_byte.push_back(msh);
            q_start.push_back(mstart);
            q_ok.push_back(mstart_ok && (tx === 1'b1));
            mon = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_frames(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (q_byte.size() >= n) break;
      step(1);
    end
  endtask

  task automatic clear_q();
    q_byte.delete();
    q_start.delete();
    q_ok.delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    int         n0;
    int         at;
    logic [7:0] t3 [3];
    logic [7:0] t4 [6];

    t3 = '{8'h61, 8'h62, 8'h0A};
    t4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rst_n = 1'b0;
    wr    = 1'b0;
    data  = 8'h00;

    // 1. reset held three cycles
    step(3);
    chk("rst_tx",    32'(tx),    32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    rst_n = 1'b1;
    step(2);

    // 2. single byte 0x61, latency, bit timing, done pulse
    n0 = cyc;
    wr = 1'b1;
    data = 8'h61;
    step(1);
    wr = 1'b0;
    chk("t2_tx_n1",   32'(tx),   32'd1);
    step(1);
    chk("t2_tx_n2",   32'(tx),   32'd0);
    chk("t2_busy",    32'(busy), 32'd1);
    chk("t2_empty",   32'(empty), 32'd1);
    step(CLKS - 1);
    chk("t2_start_end", 32'(tx), 32'd0);
    step(1);
    chk("t2_bit0",    32'(tx),   32'd1);
    step(CLKS);
    chk("t2_bit1",    32'(tx),   32'd0);
    wait_done(FRAME, at);
    chk("t2_done_at", 32'(at),   32'(n0 + 2 + FRAME - 1));
    // write during the final stop cycle: SM goes idle, then starts a cycle later
    wr = 1'b1;
    data = 8'h55;
    step(1);
    wr = 1'b0;
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_idle_done", 32'(done), 32'd0);
    chk("t2_idle_tx",   32'(tx),   32'd1);
    step(1);
    chk("t2_late_tx",   32'(tx),   32'd0);
    chk("t2_late_busy", 32'(busy), 32'd1);
    chk("t2_nframes",   32'(q_byte.size()), 32'd1);
    if (q_byte.size() >= 1) begin
      chk("t2_byte",  32'(q_byte[0]),  32'h61);
      chk("t2_start", 32'(q_start[0]), 32'(n0 + 2));
      chk("t2_frame", 32'(q_ok[0]),    32'd1);
    end
    pulse_reset();
    chk("t2_rst_tx", 32'(tx), 32'd1);
    step(1);
    clear_q();

    // 3. three consecutive writes, back-to-back frames
    n0 = cyc;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      data = t3[i];
      step(1);
    end
    wr = 1'b0;
    wait_frames(3, 3 * FRAME + 2000);
    chk("t3_nframes", 32'(q_byte.size()), 32'd3);
    for (int i = 0; i < 3 && i < q_byte.size(); i++) begin
      chk($sformatf("t3_byte%0d", i),  32'(q_byte[i]),  32'(t3[i]));
      chk($sformatf("t3_start%0d", i), 32'(q_start[i]), 32'(n0 + 2 + i * FRAME));
      chk($sformatf("t3_frame%0d", i), 32'(q_ok[i]),    32'd1);
    end
    wait_done(CLKS, at);
    chk("t3_done_at", 32'(at), 32'(n0 + 1 + 3 * FRAME));
    step(1);
    chk("t3_busy_end", 32'(busy), 32'd0);
    step(5);
    clear_q();

    // 4. six writes: one popped, four fill, sixth dropped
    n0 = cyc;
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1;
      data = t4[i];
      step(1);
      if (i == 4) begin
        chk("t4_full",  32'(full),  32'd1);
        chk("t4_level", 32'(level), 32'd4);
        chk("t4_ovf0",  32'(ovf),   32'd0);
      end
    end
    wr = 1'b0;
    chk("t4_ovf_pulse", 32'(ovf), 32'd1);
    step(1);
    chk("t4_ovf_clear",  32'(ovf),   32'd0);
    chk("t4_level_hold", 32'(level), 32'd4);
    wait_frames(5, 5 * FRAME + 2000);
    wait_done(CLKS, at);
    step(100);
    chk("t4_nframes", 32'(q_byte.size()), 32'd5);
    for (int i = 0; i < 5 && i < q_byte.size(); i++) begin
      chk($sformatf("t4_byte%0d", i), 32'(q_byte[i]), 32'(t4[i]));
    end
    chk("t4_busy_end",  32'(busy),  32'd0);
    chk("t4_empty_end", 32'(empty), 32'd1);
    clear_q();

    // 5. reset during data bit 3 of 0x62 with two bytes queued
    n0 = cyc;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1;
      data = (i == 0) ? 8'h62 : 8'(8'h11 * i);
      step(1);
    end
    wr = 1'b0;
    step(n0 + 2 + 4 * CLKS + HALF - cyc);
    chk("t5_bit3",  32'(tx),    32'd0);
    chk("t5_level", 32'(level), 32'd2);
    pulse_reset();
    chk("t5_rst_tx",    32'(tx),    32'd1);
    chk("t5_rst_empty", 32'(empty), 32'd1);
    chk("t5_rst_level", 32'(level), 32'd0);
    chk("t5_rst_busy",  32'(busy),  32'd0);
    step(FRAME + 100);
    chk("t5_no_frames", 32'(q_byte.size()), 32'd0);
    chk("t5_idle_tx",   32'(tx),   32'd1);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // 6. write while full and the SM pops in the same cycle
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1;
      data = 8'hA0 + 8'(i);
      step(1);
    end
    wr = 1'b0;
    step(1);
    chk("t6_full_pre", 32'(full), 32'd1);
    wait_done(FRAME + 100, at);
    chk("t6_done_seen", 32'(at >= 0), 32'd1);
    wr = 1'b1;
    data = 8'hA5;
    step(1);
    wr = 1'b0;
    chk("t6_ovf",    32'(ovf),   32'd0);
    chk("t6_level",  32'(level), 32'd4);
    chk("t6_full",   32'(full),  32'd1);
    chk("t6_b2b_tx", 32'(tx),    32'd0);
    step(1);
    chk("t6_ovf_next",   32'(ovf),   32'd0);
    chk("t6_level_next", 32'(level), 32'd4);
    chk("t6_nframes",    32'(q_byte.size()), 32'd1);
    if (q_byte.size() >= 1) begin
      chk("t6_byte0", 32'(q_byte[0]), 32'hA0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
